// File: rtl/scratch_load_scheduler.sv
// Bulk-load sequencer: pops a FWFT read buffer into a scratchpad write port
// with wrapping addresses, under buffer-empty, stall and abort back-pressure.
module scratch_load_scheduler #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              buf_valid,
  input  logic [DATA_W-1:0] buf_dout,
  output logic              buf_ren,
  input  logic              stall,
  output logic              scratch_wen,
  output logic [ADDR_W-1:0] scratch_waddr,
  output logic [DATA_W-1:0] scratch_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_left
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LP_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_err;
  logic                w_xfer;
  logic                w_accept;
  logic                w_illegal;
  logic                w_abort;
  logic                w_legal;

  // Start address is zero-extended so DEPTH == 2**ADDR_W still compares correctly.
  assign w_legal = (load_len != '0) && (load_len <= LP_DEPTH) &&
                   ({1'b0, start_addr} < LP_DEPTH);

  always_comb begin
    w_next    = r_state;
    w_xfer    = 1'b0;
    w_accept  = 1'b0;
    w_illegal = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_legal) begin
            w_accept = 1'b1;
            w_next   = S_LOAD;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (buf_valid && !stall) begin
          w_xfer = 1'b1;
          if (r_remaining == LP_ONE) w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_illegal;
      if (w_accept) begin
        r_addr      <= start_addr;
        r_remaining <= load_len;
      end else if (w_abort) begin
        r_remaining <= '0;
      end else if (w_xfer) begin
        r_addr      <= (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
        r_remaining <= r_remaining - LP_ONE;
      end
    end
  end

  // Pop and write are the same event, so a word is never dropped.
  assign buf_ren       = w_xfer;
  assign scratch_wen   = w_xfer;
  assign scratch_waddr = r_addr;
  assign scratch_wdata = buf_dout;
  assign busy          = (r_state == S_LOAD) || (r_state == S_DONE);
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign words_left    = r_remaining;

endmodule

// File: tb/tb_scratch_load_scheduler.sv
// Scoreboard bench for scratch_load_scheduler (DEPTH=16, ADDR_W=5 so that an
// out-of-range start address of 16 can be presented).
module tb_scratch_load_scheduler;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   load_len;
  logic              abort;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_dout;
  logic              buf_ren;
  logic              stall;
  logic              scratch_wen;
  logic [ADDR_W-1:0] scratch_waddr;
  logic [DATA_W-1:0] scratch_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_left;

  scratch_load_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .load_len     (load_len),
    .abort        (abort),
    .buf_valid    (buf_valid),
    .buf_dout     (buf_dout),
    .buf_ren      (buf_ren),
    .stall        (stall),
    .scratch_wen  (scratch_wen),
    .scratch_waddr(scratch_waddr),
    .scratch_wdata(scratch_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_left   (words_left)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [ADDR_W:0]   wl;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_done  = 0;
  int          n_writes = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic [DATA_W-1:0] head_val = 16'hA000;
  logic [DATA_W-1:0] exp_data = 16'hA000;

  assign buf_dout = head_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    chk("ren_eq_wen", {31'd0, buf_ren}, {31'd0, scratch_wen});
    chk("wen_gated", {31'd0, scratch_wen & (stall | ~buf_valid | abort)}, 32'd0);
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (scratch_wen) begin
      n_writes++;
      if (sb.size() == 0) begin
        chk("extra_write", {31'd0, scratch_wen}, 32'd0);
      end else begin
        chk("waddr", 32'(scratch_waddr), 32'(sb[0].a));
        chk("wdata", 32'(scratch_wdata), 32'(sb[0].d));
        chk("wleft", 32'(words_left), 32'(sb[0].wl));
        void'(sb.pop_front());
      end
      head_val = head_val + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input int n, input int len);
    int a;
    a = addr;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{a: ADDR_W'(a), d: exp_data, wl: (ADDR_W+1)'(len - i)});
      exp_data = exp_data + 1'b1;
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
  endtask

  task automatic load(input int addr, input int len, input int nexp);
    start      = 1'b1;
    start_addr = ADDR_W'(addr);
    load_len   = (ADDR_W+1)'(len);
    push_exp(addr, nexp, len);
    tick();
    start     = 1'b0;
    start_cyc = cyc;
    chk("busy_acc", {31'd0, busy}, 32'd1);
    chk("wl_init", 32'(words_left), 32'(len));
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy) break;
    end
    chk({"idle_", tag}, {31'd0, busy}, 32'd0);
  endtask

  task automatic illegal(input int addr, input int len);
    start      = 1'b1;
    start_addr = ADDR_W'(addr);
    load_len   = (ADDR_W+1)'(len);
    tick();
    start = 1'b0;
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("err_clear", {31'd0, err}, 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; start_addr = '0; load_len = '0;
    abort = 1'b0; buf_valid = 1'b0; stall = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wen", {31'd0, scratch_wen}, 32'd0);
    chk("rst_ren", {31'd0, buf_ren}, 32'd0);
    chk("rst_waddr", 32'(scratch_waddr), 32'd0);
    chk("rst_wleft", 32'(words_left), 32'd0);
    #9 rst = 1'b1;
    tick();

    // Basic load
    buf_valid = 1'b1;
    d0 = n_done;
    load(0, 4, 4);
    wait_idle("basic", 20);
    chk("basic_done_cnt", 32'(n_done - d0), 32'd1);
    chk("basic_done_lat", 32'(done_cyc - start_cyc), 32'd4);
    chk("basic_sb_empty", 32'(sb.size()), 32'd0);

    // Wrap
    d0 = n_writes;
    load(14, 5, 5);
    wait_idle("wrap", 20);
    chk("wrap_writes", 32'(n_writes - d0), 32'd5);
    chk("wrap_wleft0", 32'(words_left), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure
    d0 = n_done;
    buf_valid = 1'b1;
    load(3, 6, 6);
    for (int c = 0; c < 60; c++) begin
      buf_valid = ((c / 2) % 2) == 0;
      stall     = (c == 3) || (c == 4);
      tick();
      if (!busy) break;
    end
    stall = 1'b0;
    chk("bp_idle", {31'd0, busy}, 32'd0);
    chk("bp_done_cnt", 32'(n_done - d0), 32'd1);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Illegal commands
    buf_valid = 1'b1;
    d0 = n_writes;
    illegal(0, 0);
    illegal(0, 17);
    illegal(16, 4);
    chk("illegal_no_write", 32'(n_writes - d0), 32'd0);

    // Abort after three writes
    d0 = n_done;
    load(2, 8, 3);
    tick(); tick(); tick();
    abort = 1'b1;
    #1;
    chk("abort_no_wen", {31'd0, scratch_wen}, 32'd0);
    tick();
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_wleft", 32'(words_left), 32'd0);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    load(9, 2, 2);
    wait_idle("post_abort", 20);
    chk("abort_done_cnt", 32'(n_done - d0), 32'd1);
    chk("post_abort_sb", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-load
    buf_valid = 1'b0;
    load(5, 4, 0);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_wen", {31'd0, scratch_wen}, 32'd0);
    chk("arst_ren", {31'd0, buf_ren}, 32'd0);
    chk("arst_waddr", 32'(scratch_waddr), 32'd0);
    chk("arst_wleft", 32'(words_left), 32'd0);
    rst = 1'b1;
    tick();
    buf_valid = 1'b1;
    d0 = n_done;
    load(7, 1, 1);
    wait_idle("single", 10);
    chk("single_done_cnt", 32'(n_done - d0), 32'd1);
    chk("single_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    chk("single_sb_empty", 32'(sb.size()), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
